// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_file_pkg
// Description : Shared helpers for the scoreboarded register file: the
//               address-width function and the hardwired-zero address.
// Revision    : 1.0 - initial release
// ============================================================================
package register_file_pkg;

    // Address of the optional hardwired zero register.
    localparam int unsigned ZERO_ADDR = 0;

    // Address width for a register count; never narrower than one bit.
    function automatic int reg_addr_width(input int reg_count);
        int w;
        w = $clog2(reg_count);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : register_file_pkg
`default_nettype wire

// File: rtl/scoreboarded_register_file_busy_table.sv
`default_nettype none
// ============================================================================
// Module      : busy_table
// Description : Busy-bit scoreboard. Holds one pending-producer bit per
//               register and applies clear (writeback), set (reservation)
//               and flush. It also produces rsv_ready and a registered
//               popcount of the busy bits.
// Ports       : clk, rst_n         - clock, async active-low reset
//               wr_en, wr_addr     - writeback clears a busy bit
//               rsv_valid/addr     - issue reservation request
//               rsv_ready          - reservation accepted this cycle
//               flush              - clear every busy bit
//               busy               - current busy bits (to read muxes)
//               busy_count         - registered number of busy bits
// Revision    : 1.0 - initial release
// ============================================================================
module busy_table
    import register_file_pkg::*;
#(
    parameter int REG_COUNT = 32,
    parameter int ZERO_REG  = 1,
    parameter int AW        = reg_addr_width(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 rsv_ready,
    input  logic                 flush,
    output logic [REG_COUNT-1:0] busy,
    output logic [AW:0]          busy_count
);

    localparam bit c_zero_en = (ZERO_REG != 0);

    logic [REG_COUNT-1:0] r_busy;
    logic [REG_COUNT-1:0] w_busy_next;
    logic [AW:0]          r_busy_count;
    logic [AW:0]          w_count_next;
    logic                 w_rsv_ready;

    // A register whose producer is retiring this very cycle can be reserved
    // again: the write clears the old reservation before the new one lands.
    // With the zero register its busy bit is pinned to 0, so this is 1 there.
    assign w_rsv_ready = !r_busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr));

    // Order sets the priority: clear, then set (new producer wins), then flush.
    always_comb begin
        w_busy_next = r_busy;
        if (wr_en) begin
            w_busy_next[wr_addr] = 1'b0;
        end
        if (rsv_valid && w_rsv_ready) begin
            w_busy_next[rsv_addr] = 1'b1;
        end
        if (flush) begin
            w_busy_next = '0;
        end
        if (c_zero_en) begin
            w_busy_next[ZERO_ADDR] = 1'b0;
        end
    end

    // Count is taken from the next state so the registered value tracks the
    // busy bits after each edge.
    always_comb begin
        w_count_next = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            w_count_next = w_count_next + {{AW{1'b0}}, w_busy_next[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_busy       <= w_busy_next;
            r_busy_count <= w_count_next;
        end
    end

    assign busy       = r_busy;
    assign busy_count = r_busy_count;
    assign rsv_ready  = w_rsv_ready;

endmodule : busy_table
`default_nettype wire

// File: rtl/scoreboarded_register_file.sv
`default_nettype none
// ============================================================================
// Module      : scoreboarded_register_file
// Description : Parametrised register file with READ_PORTS combinational read
//               ports, one write port with same-cycle bypass, an optional
//               hardwired zero register and a busy-bit scoreboard.
// Ports       : clk, rst_n          - clock, async active-low reset
//               rd_addr / rd_data   - packed read addresses / data
//               rd_busy             - per-port operand-pending flag
//               wr_en/addr/data     - writeback port
//               rsv_valid/addr      - issue reservation request
//               rsv_ready           - reservation accepted
//               flush               - clear all reservations
//               busy_count          - registered busy-register count
// Revision    : 1.0 - initial release
// ============================================================================
module scoreboarded_register_file
    import register_file_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_COUNT  = 32,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    localparam int AW        = reg_addr_width(REG_COUNT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [READ_PORTS*AW-1:0]   rd_addr,
    output logic [READ_PORTS*XLEN-1:0] rd_data,
    output logic [READ_PORTS-1:0]      rd_busy,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    input  logic                       rsv_valid,
    input  logic [AW-1:0]              rsv_addr,
    output logic                       rsv_ready,
    input  logic                       flush,
    output logic [AW:0]                busy_count
);

    localparam bit c_zero_en = (ZERO_REG != 0);

    logic [XLEN-1:0]      r_regs [REG_COUNT];
    logic [REG_COUNT-1:0] w_busy;
    logic                 w_wr_zero;

    assign w_wr_zero = c_zero_en && (wr_addr == AW'(ZERO_ADDR));

    busy_table #(
        .REG_COUNT (REG_COUNT),
        .ZERO_REG  (ZERO_REG),
        .AW        (AW)
    ) u_busy_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .rsv_ready  (rsv_ready),
        .flush      (flush),
        .busy       (w_busy),
        .busy_count (busy_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en && !w_wr_zero) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        logic            w_pend;

        assign w_addr = rd_addr[p*AW +: AW];

        // Zero register beats bypass so a write to r0 never leaks through.
        always_comb begin
            w_data = r_regs[w_addr];
            w_pend = w_busy[w_addr];
            if (c_zero_en && (w_addr == AW'(ZERO_ADDR))) begin
                w_data = '0;
                w_pend = 1'b0;
            end else if (wr_en && (wr_addr == w_addr)) begin
                w_data = wr_data;
                w_pend = 1'b0;
            end
        end

        assign rd_data[p*XLEN +: XLEN] = w_data;
        assign rd_busy[p]              = w_pend;
    end : g_read

endmodule : scoreboarded_register_file
`default_nettype wire

// File: doc/scoreboarded_register_file.md
# scoreboarded_register_file

Parametrised successor to the integer register file. It has N combinational read ports, one write port with same-cycle write-to-read bypass, and an optional hardwired zero register. A busy-bit scoreboard sits beside the data array: issue reserves a destination register, writeback clears the reservation, and flush clears all pending reservations. The block sits between decode/issue (reads, reserve) and writeback (write) in the pipelined core.

## Interface
- `XLEN`, default 32: data width of each register.
- `REG_COUNT`, default 32: number of registers; power of two, ≥ 2.
- `READ_PORTS`, default 2: number of independent read ports, ≥ 1.
- `ZERO_REG`, default 1: when 1, register 0 reads as 0, ignores writes and is never busy.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rd_addr`  in  READ_PORTS*AW  packed read addresses; port i is bits [i*AW +: AW], AW = $clog2(REG_COUNT).
- `rd_data`  out  READ_PORTS*XLEN  packed read data; port i is bits [i*XLEN +: XLEN].
- `rd_busy`  out  READ_PORTS  port i operand still pending (no valid value yet).
- `wr_en`  in  1  write enable (writeback commit).
- `wr_addr`  in  AW  write address.
- `wr_data`  in  XLEN  write data.
- `rsv_valid`  in  1  issue requests a reservation of `rsv_addr`.
- `rsv_addr`  in  AW  destination register to reserve.
- `rsv_ready`  out  1  the reservation is accepted this cycle.
- `flush`  in  1  synchronous clear of all busy bits.
- `busy_count`  out  AW+1  number of currently busy registers.

## Operation
- Reset (`rst_n` low, any time, including mid-operation): all registers become 0, all busy bits become 0, `busy_count` becomes 0. Outputs then follow combinationally: `rd_data` = 0, `rd_busy` = 0, `rsv_ready` = 1.
- Read, per port, combinational:
  - If `ZERO_REG` is set and the address is 0: data 0, busy 0.
  - Else, if `wr_en` is high and `wr_addr` equals the read address: data = `wr_data`, busy 0 (bypass).
  - Else: data = stored value, busy = busy bit.
- Write: on the edge with `wr_en` high, store `wr_data` and clear the busy bit of `wr_addr`. A write to a register that is not busy is legal and is a plain write. A write to address 0 with `ZERO_REG` set has no effect.
- Reservation handshake: `rsv_ready` = !busy[rsv_addr] || (wr_en && wr_addr == rsv_addr). This blocks write-after-write on an un-retired producer.
  - A transfer occurs when `rsv_valid && rsv_ready`; the busy bit is then set on the edge.
  - `rsv_ready` does not depend on `rsv_valid`.
  - Reserving address 0 with `ZERO_REG` set: `rsv_ready` = 1, and no state changes.
- Simultaneous write and reservation on the same address: the data is stored and the busy bit ends up set, because the new producer wins.
- `flush` has priority over reservation:
  - All busy bits are 0 after the edge.
  - A same-cycle write still stores its data.
  - A same-cycle reservation is dropped, but `rsv_ready` is still reported as computed above.
- `busy_count` is registered. It is the popcount of the busy bits after each edge; it saturates naturally at REG_COUNT (REG_COUNT−1 with `ZERO_REG`).

## Timing
- Read latency 0: combinational from `rd_addr`, `wr_*` and state.
- Write-to-read: visible in the same cycle via bypass, and from the array on the next cycle.
- Reserve-to-`rd_busy`: 1 cycle. A reservation made in cycle t is seen by reads in cycle t+1, not t.
- Writeback clears busy: the read in the same cycle already sees busy 0 via bypass.
- `busy_count` reflects state one cycle after the causing edge.
- No combinational path from `rsv_valid` to any output.

## Structure
- Package `register_file_pkg` holds the address-width function `reg_addr_width(REG_COUNT)` and the constant `ZERO_ADDR`.
- Sub-module `busy_table` holds the busy bits, the set/clear/flush priority, the `rsv_ready` logic and the `busy_count` popcount.
- The top level holds the data array, the read muxes and the bypass.
- Read ports are built with a generate loop over `READ_PORTS`.

## Test plan
- Reset then reads: with `rst_n` pulsed low mid-run after writes, all `rd_data` = 0, `busy_count` = 0 and `rsv_ready` = 1 while low and after release.
- Zero register: write 0x3f3f3f3f to addr 0, then read port 0 at addr 0 returns 0x00000000 with busy 0. Reserve addr 0 gives `rsv_ready` 1 and `busy_count` stays 0.
- Write/read/bypass: write 0x3f3f3f3f to addr 1 while port 1 reads addr 1, so the same cycle returns 0x3f3f3f3f. The next cycle after `wr_en` drops still returns 0x3f3f3f3f.
- Scoreboard:
  - Reserve addr 5 in cycle t; `rd_busy` for addr 5 reads 0 in cycle t and 1 in cycle t+1, and `busy_count` = 1.
  - A second reserve of addr 5 sees `rsv_ready` 0.
  - Write 0xfcfcfcfc to addr 5: `rsv_ready` 1 and bypass data 0xfcfcfcfc with busy 0 in that cycle, then `busy_count` 0.
- Same-cycle reserve plus write on addr 7: afterwards the data is the written value, busy is 1 and `busy_count` = 1.
- Flush: reserve addrs 2, 3 and 4, then assert `flush` together with a reservation of addr 6. Afterwards all busy bits are 0, `busy_count` is 0 and addr 6 is not busy.
